// File: rtl/bcd_pkg.sv
// Shared BCD constants, counter state encoding and the nibble clamp helper
// used by the BCD down-counter and its digit cells.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] i_nib);
      return (i_nib > BCD_MAX) ? BCD_MAX : i_nib;
   endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the down-counter: load has priority over a borrow step,
// result registered (1 cycle); borrow ripples combinationally to the next digit.
module bcd_digit_dn
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_load,
   input  logic [3:0] i_load_dat,
   input  logic       i_borrow_in,
   output logic [3:0] o_digit,
   output logic       o_borrow_out,
   output logic       o_zero
);

   logic [3:0] r_digit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_digit <= BCD_ZERO;
      end else if (i_load) begin
         r_digit <= i_load_dat;
      end else if (i_borrow_in) begin
         r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
      end
   end

   assign o_digit      = r_digit;
   assign o_zero       = (r_digit == BCD_ZERO);
   assign o_borrow_out = i_borrow_in && o_zero;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: load via valid/ready (refused while counting), done/bout one cycle
// after the enabled edge at zero. BCD_DOWN_COUNTER_AUTO_RELOAD_EN makes terminal count reload and keep running.
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*DIGITS-1:0] load_data,
   input  logic                en,
   input  logic                abort,
   output logic [4*DIGITS-1:0] cnt,
   output logic                busy,
   output logic                done,
   output logic                bout,
   output logic                load_err
);

   state_t r_state;
   state_t w_next;
   logic   w_load;
   logic   w_dec;
   logic   w_term;
   logic   r_done;
   logic   r_load_err;

   logic [4*DIGITS-1:0] w_ld_clamp;
   logic [4*DIGITS-1:0] w_dig_dat;
   logic                w_dig_load;
   logic [DIGITS-1:0]   w_nib_err;
   logic [DIGITS-1:0]   w_zero;
   logic [DIGITS-1:0]   w_borrow;
   logic                w_cnt_zero;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic w_bin;
         assign w_ld_clamp[4*gi +: 4] = bcd_clamp(load_data[4*gi +: 4]);
         assign w_nib_err[gi]         = (load_data[4*gi +: 4] > BCD_MAX);
         if (gi == 0) begin : g_lsd
            assign w_bin = w_dec;
         end else begin : g_upper
            assign w_bin = w_borrow[gi-1];
         end
         bcd_digit_dn u_digit (
            .clk          (clk),
            .rstn         (rstn),
            .i_load       (w_dig_load),
            .i_load_dat   (w_dig_dat[4*gi +: 4]),
            .i_borrow_in  (w_bin),
            .o_digit      (cnt[4*gi +: 4]),
            .o_borrow_out (w_borrow[gi]),
            .o_zero       (w_zero[gi])
         );
      end
   endgenerate

   assign w_cnt_zero = &w_zero;

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
   logic [4*DIGITS-1:0] r_shadow;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shadow <= '0;
      end else if (w_load) begin
         r_shadow <= w_ld_clamp;
      end
   end

   assign w_dig_load = w_load || w_term;
   assign w_dig_dat  = w_load ? w_ld_clamp : r_shadow;
`else
   assign w_dig_load = w_load;
   assign w_dig_dat  = w_ld_clamp;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_dec  = 1'b0;
      w_term = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (load_valid) begin
               w_load = 1'b1;
               w_next = RUN;
            end
         end
         RUN: begin
            // abort outranks en, so a same-cycle enable never decrements
            if (abort) begin
               w_next = IDLE;
            end else if (en) begin
               if (w_cnt_zero) begin
                  w_term = 1'b1;
`ifndef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
                  w_next = DONE;
`endif
               end else begin
                  w_dec = 1'b1;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_done     <= w_term;
         r_load_err <= w_load && (|w_nib_err);
      end
   end

   assign load_ready = (r_state != RUN);
   assign busy       = (r_state == RUN);
   assign done       = r_done;
   assign bout       = r_done;
   assign load_err   = r_load_err;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for the 4-digit BCD down-counter; inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_bcd_down_counter;

   logic        clk;
   logic        rstn;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic        en;
   logic        abort;
   logic [15:0] cnt;
   logic        busy;
   logic        done;
   logic        bout;
   logic        load_err;

   int n_checks;
   int n_fail;

   bcd_down_counter #(.DIGITS(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .en         (en),
      .abort      (abort),
      .cnt        (cnt),
      .busy       (busy),
      .done       (done),
      .bout       (bout),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'((v)        % 10);
      r[7:4]   = 4'((v / 10)   % 10);
      r[11:8]  = 4'((v / 100)  % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] d);
      load_valid = 1'b1;
      load_data  = d;
      step();
      load_valid = 1'b0;
   endtask

   initial begin
      int k;
      int n_done;
      n_checks   = 0;
      n_fail     = 0;
      rstn       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      en         = 1'b0;
      abort      = 1'b0;

      #3;
      chk("rst_cnt",   32'(cnt), 32'h0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_bout",  32'(bout), 32'd0);
      chk("rst_lerr",  32'(load_err), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      step();
      rstn = 1'b1;
      step();

      // 0012 counting to terminal with en held high
      en = 1'b1;
      do_load(16'h0012);
      chk("t1_load_cnt",   32'(cnt), 32'h0012);
      chk("t1_load_busy",  32'(busy), 32'd1);
      chk("t1_load_ready", 32'(load_ready), 32'd0);
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("t1_cnt",  32'(cnt), 32'(to_bcd(12 - i)));
         chk("t1_done", 32'(done), 32'd0);
      end
      step();
      chk("t1_term_done",  32'(done), 32'd1);
      chk("t1_term_bout",  32'(bout), 32'd1);
      chk("t1_term_cnt",   32'(cnt), 32'h0);
      chk("t1_term_busy",  32'(busy), 32'd0);
      chk("t1_term_ready", 32'(load_ready), 32'd1);
      step();
      chk("t1_post_done", 32'(done), 32'd0);
      chk("t1_post_bout", 32'(bout), 32'd0);
      chk("t1_post_cnt",  32'(cnt), 32'h0);

      // 1000: full borrow ripple, done after 1001 enabled cycles
      do_load(16'h1000);
      k = 0;
      for (int i = 1; i <= 1100; i++) begin
         step();
         if (i == 1) chk("t2_first", 32'(cnt), 32'h0999);
         if (done) begin
            k = i;
            break;
         end
      end
      chk("t2_done_cycle", 32'(k), 32'd1001);

      // non-BCD nibble clamps and flags load_err
      en = 1'b0;
      do_load(16'h00A5);
      chk("t3_clamp_cnt", 32'(cnt), 32'h0095);
      chk("t3_lerr",      32'(load_err), 32'd1);
      step();
      chk("t3_lerr_off",  32'(load_err), 32'd0);
      chk("t3_hold_cnt",  32'(cnt), 32'h0095);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t3_abort_busy", 32'(busy), 32'd0);
      chk("t3_abort_cnt",  32'(cnt), 32'h0095);

      // load of zero terminates after one enabled cycle
      en = 1'b1;
      do_load(16'h0000);
      chk("t3_zero_cnt",  32'(cnt), 32'h0);
      chk("t3_zero_nodn", 32'(done), 32'd0);
      step();
      chk("t3_zero_done", 32'(done), 32'd1);
      chk("t3_zero_bout", 32'(bout), 32'd1);
      step();
      chk("t3_zero_off",  32'(done), 32'd0);

      // en toggling, then abort together with en
      en = 1'b0;
      do_load(16'h0050);
      for (int i = 0; i < 6; i++) begin
         en = ((i % 2) == 0);
         step();
         chk("t4_toggle_cnt", 32'(cnt), 32'(to_bcd(50 - (i / 2) - 1)));
      end
      abort = 1'b1;
      en    = 1'b1;
      step();
      abort = 1'b0;
      en    = 1'b0;
      chk("t4_abort_busy",  32'(busy), 32'd0);
      chk("t4_abort_cnt",   32'(cnt), 32'h0047);
      chk("t4_abort_done",  32'(done), 32'd0);
      chk("t4_abort_ready", 32'(load_ready), 32'd1);
      en = 1'b1;
      step();
      chk("t4_idle_cnt",  32'(cnt), 32'h0047);
      chk("t4_idle_done", 32'(done), 32'd0);

      // asynchronous reset mid-countdown
      do_load(16'h0040);
      repeat (9) step();
      chk("t5_pre_cnt", 32'(cnt), 32'h0031);
      #2;
      rstn = 1'b0;
      #1;
      chk("t5_arst_cnt",   32'(cnt), 32'h0);
      chk("t5_arst_busy",  32'(busy), 32'd0);
      chk("t5_arst_ready", 32'(load_ready), 32'd1);
      step();
      rstn = 1'b1;
      step();

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      en = 1'b1;
      do_load(16'h0003);
      n_done = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (done) n_done++;
         if (i == 4) chk("t6_done_at4", 32'(done), 32'd1);
         if (i == 4) chk("t6_reload_cnt", 32'(cnt), 32'h0003);
         chk("t6_busy", 32'(busy), 32'd1);
      end
      chk("t6_n_done", 32'(n_done), 32'd3);
`else
      n_done = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
